ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit sitting directly upstream of the instruction memory and downstream of the execute/branch-resolution logic. Holds the program counter, drives the combinational IM read address, captures the returned word together with its PC into a small in-order queue, and presents it to decode through a valid/ready handshake. It handles redirects from branches and jumps by flushing the queue. It also flags fetches that fall outside the IM window or are misaligned.

## Interface
- PC_RESET, 32'h0000_3000, PC value after reset and base address of the IM window
- IM_WORDS, 2048, number of 32-bit words in IM; valid window is [PC_RESET, PC_RESET + 4*IM_WORDS)
- QDEPTH, 2, fetch-queue entries (power of two, ≥2)

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- im_addr  out  32  byte address to IM; combinationally equal to the current PC
- im_instr  in  32  instruction word returned combinationally by IM for im_addr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  32  new PC when redirect_valid=1
- out_valid  out  1  queue head holds an entry
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction; 0 when out_valid=0
- out_pc  out  32  head PC; 0 when out_valid=0
- out_fault  out  1  head entry is a fetch fault; 0 when out_valid=0

## Operation
- State: pc (32), queue of QDEPTH entries {pc, instr, fault}, count (0..QDEPTH), halted (1).
- fault_now = (pc[1:0] != 0) or pc < PC_RESET or pc ≥ PC_RESET + 4*IM_WORDS. Compare in 33-bit arithmetic so the upper bound does not wrap.
- pop = out_valid & out_ready.
- fetch = !redirect_valid & !halted & (count < QDEPTH or pop).
- On fetch: push {pc, fault_now ? 32'h0 : im_instr, fault_now}.
  - If fault_now: halted ← 1, pc holds.
  - Else: pc ← pc + 4.
- Push and pop in the same cycle keep count unchanged; the queue is strictly in order.
- On redirect_valid=1 (highest priority): queue flushed (count ← 0), pc ← redirect_target, halted ← 0, no push. A simultaneous pop is discarded with the flush.
- A misaligned or out-of-range redirect_target is accepted into pc. It produces a fault entry on the next fetch.
- While halted, im_addr still equals pc, and entries already queued continue to drain normally.

## Timing
- Reset values (asynchronous on rst_n=0):
  - pc = PC_RESET, count = 0, halted = 0
  - out_valid = 0, out_instr = 0, out_pc = 0, out_fault = 0
  - im_addr = PC_RESET
- Fetch latency: an entry pushed at edge N is visible on out_* after edge N.
  - After reset release, the first edge pushes PC_RESET; out_valid=1 after that edge.
- Redirect latency: redirect asserted in cycle N → out_valid=0 in cycle N+1 (flush). The target entry is pushed at the end of cycle N+1 and appears in cycle N+2.
- Full queue with out_ready=0: pc and im_addr hold, no push.
- Full queue with out_ready=1: push and pop in the same cycle; sustained throughput is 1 instruction/cycle.
- Wrap-around: after the last word (PC_RESET + 4*IM_WORDS − 4), pc becomes the first out-of-window address. The next fetch is a fault entry, then the unit halts.
- Reset mid-operation: all state returns to reset values immediately, regardless of queue contents or halted.

## Test plan
- Reset, then out_ready=1 constant, IM holding word k = 0x1000_0000+k → out_pc = 0x3000, 0x3004, 0x3008 on consecutive cycles with the matching out_instr; out_fault=0.
- out_ready=0 for 5 cycles after reset → count saturates at 2 with entries 0x3000 and 0x3004; im_addr holds 0x3008. Raising out_ready then yields 0x3000, 0x3004, 0x3008 back-to-back with no gap.
- Full queue with redirect_valid=1, target 0x3100, and out_ready=1 in the same cycle → the pop is discarded, out_valid=0 in the next cycle, and out_pc=0x3100 one cycle later.
- Redirect to 0x4FFC (IM_WORDS=2048), out_ready=1 → entry 0x4FFC with fault=0, then entry 0x5000 with out_instr=0 and out_fault=1. im_addr stays 0x5000 and no further entries appear until a redirect to 0x3000 resumes fetch.
- Redirect to 0x3002 → one entry with out_pc=0x3002, out_fault=1, then halt. Redirect to 0x2FFC → fault entry, then halt.
- Drop rst_n asynchronously mid-cycle with 2 queued entries and halted=1 → out_valid=0 and im_addr=0x3000 immediately. After release, the stream restarts from 0x3000.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, reads IM combinationally, and buffers
// {pc, instr, fault} in a small in-order queue toward decode.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 2048,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  localparam int          AW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(QDEPTH);
  // 33-bit window bounds so PC_RESET + 4*IM_WORDS cannot wrap
  localparam logic [32:0] WIN_LO   = {1'b0, PC_RESET};
  localparam logic [32:0] WIN_HI   = WIN_LO + (33'(IM_WORDS) << 2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fq_ent_t;

  fq_ent_t       r_q [QDEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_cnt;
  logic [31:0]   r_pc;
  logic          r_halted;

  logic    w_fault, w_pop, w_fetch;
  fq_ent_t w_push_ent, w_head;

  always_comb begin
    w_fault = (r_pc[1:0] != 2'b00) || ({1'b0, r_pc} < WIN_LO) || ({1'b0, r_pc} >= WIN_HI);
    w_pop   = out_valid & out_ready;
    w_fetch = !redirect_valid && !r_halted && ((r_cnt != CNT_FULL) || w_pop);
    w_push_ent.pc    = r_pc;
    w_push_ent.instr = w_fault ? 32'h0 : im_instr;
    w_push_ent.fault = w_fault;
    w_head = r_q[r_head];
  end

  assign im_addr   = r_pc;
  assign out_valid = (r_cnt != '0);
  assign out_pc    = out_valid ? w_head.pc    : 32'h0;
  assign out_instr = out_valid ? w_head.instr : 32'h0;
  assign out_fault = out_valid & w_head.fault;

  // Payload storage needs no reset: out_* are masked by the count.
  always_ff @(posedge clk) begin
    if (w_fetch) r_q[r_tail] <= w_push_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= PC_RESET;
      r_halted <= 1'b0;
      r_head   <= '0;
      r_tail   <= '0;
      r_cnt    <= '0;
    end else if (redirect_valid) begin
      // Flush wins over any same-cycle pop or fetch
      r_pc     <= redirect_target;
      r_halted <= 1'b0;
      r_head   <= '0;
      r_tail   <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_fetch) begin
        r_tail <= r_tail + AW'(1);
        if (w_fault) r_halted <= 1'b1;
        else         r_pc     <= r_pc + 32'd4;
      end
      if (w_pop) r_head <= r_head + AW'(1);
      case ({w_fetch, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: expected entries are queued as stimulus is
// planned and compared when decode accepts the head.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] im_addr, im_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid, out_ready = 1'b0, out_fault;
  logic [31:0] out_instr, out_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .im_addr(im_addr), .im_instr(im_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  // IM model: word k holds 0x1000_0000+k; outside the window returns junk
  always_comb begin
    if (im_addr >= 32'h3000 && im_addr < 32'h5000)
      im_instr = 32'h1000_0000 + ((im_addr - 32'h3000) >> 2);
    else
      im_instr = 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_ent(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.fault = (pc[1:0] != 2'b00) || (pc < 32'h3000) || (pc >= 32'h5000);
    e.instr = e.fault ? 32'h0 : 32'h1000_0000 + ((pc - 32'h3000) >> 2);
    sb.push_back(e);
  endtask

  // One cycle: drive inputs, check head if accepted (pe = pop expected), clock.
  task automatic cyc(input bit rdy, input bit pe, input bit rv, input logic [31:0] tgt);
    exp_t e;
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    if (rdy && !rv) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, pe});
      if (pe) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
          chk("out_fault", {31'b0, out_fault}, {31'b0, e.fault});
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_fault", {31'b0, out_fault}, 32'd0);
    chk("rst_im_addr", im_addr, 32'h3000);
    sb.delete();
    out_ready = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_now();

    // Streaming with constant ready
    expect_ent(32'h3000); expect_ent(32'h3004); expect_ent(32'h3008);
    cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0);

    // Back-pressure: queue saturates at two entries
    reset_now();
    repeat (5) cyc(0, 0, 0, 0);
    chk("bp_im_addr", im_addr, 32'h3008);
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_head", out_pc, 32'h3000);
    expect_ent(32'h3000); expect_ent(32'h3004); expect_ent(32'h3008);
    repeat (3) cyc(1, 1, 0, 0);

    // Redirect on a full queue with ready high discards the pop
    cyc(1, 0, 1, 32'h3100);
    cyc(1, 0, 0, 0);
    expect_ent(32'h3100);
    cyc(1, 1, 0, 0);

    // Last word then out-of-window fault, then halt
    cyc(1, 0, 1, 32'h4FFC);
    cyc(1, 0, 0, 0);
    expect_ent(32'h4FFC); expect_ent(32'h5000);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("halt_im_addr", im_addr, 32'h5000);
    cyc(1, 0, 0, 0);
    chk("halt_im_addr2", im_addr, 32'h5000);
    cyc(1, 0, 1, 32'h3000);
    cyc(1, 0, 0, 0);
    expect_ent(32'h3000);
    cyc(1, 1, 0, 0);

    // Misaligned and below-window redirect targets
    cyc(1, 0, 1, 32'h3002);
    cyc(1, 0, 0, 0);
    expect_ent(32'h3002);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("mis_im_addr", im_addr, 32'h3002);
    cyc(1, 0, 1, 32'h2FFC);
    cyc(1, 0, 0, 0);
    expect_ent(32'h2FFC);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("low_im_addr", im_addr, 32'h2FFC);

    // Two queued entries and halted, then async reset mid-cycle
    cyc(0, 0, 1, 32'h4FFC);
    repeat (3) cyc(0, 0, 0, 0);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("pre_rst_head", out_pc, 32'h4FFC);
    chk("pre_rst_im_addr", im_addr, 32'h5000);
    #2;
    reset_now();
    cyc(1, 0, 0, 0);
    expect_ent(32'h3000); expect_ent(32'h3004);
    repeat (2) cyc(1, 1, 0, 0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
